// File: rtl/spi_pkg.sv
// Shared types and constants for the serial-to-memory-bus bridge.
// Frame layout is LSB first: wr, then 8 address bits, then 8 data bits on writes.
package spi_pkg;

    localparam int WR_FRAME_BITS  = 17;
    localparam int RD_FRAME_BITS  = 9;
    localparam int BYTE_BITS      = RD_FRAME_BITS - 1;
    localparam int DEF_ADDR_LIMIT = 32;
    localparam int DEF_TIMEOUT    = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP,
        ST_SEND,
        ST_DONE
    } bridge_state_e;

    typedef enum logic [1:0] {
        SH_HOLD,
        SH_LOAD,
        SH_SHIFT_IN,
        SH_SHIFT_OUT
    } sh_mode_e;

    function automatic logic addr_in_range(input logic [7:0] addr, input int limit);
        return ({24'd0, addr} < limit);
    endfunction

endpackage

// File: rtl/spi_mem_bridge_if.sv
// Local req/ack memory bus between the bridge (master) and the memory (slave).
interface spi_mem_bridge_if #(
    parameter int ADDR_W = 8
) ();

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_ack;
    logic [7:0]        bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/spi_bit_shifter.sv
// LSB-first shift register with a shift counter; serves both the receive
// deserialiser (shift-in from the top) and the sdo serialiser (shift-out of bit 0).
module spi_bit_shifter
    import spi_pkg::*;
#(
    parameter int W = BYTE_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  sh_mode_e     mode_i,
    input  logic [W-1:0] din_i,
    input  logic         sdi_i,
    output logic [W-1:0] data_nxt_o,
    output logic         lsb_o,
    output logic         last_o
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  shift_in_val, shift_out_val;
    logic [CW-1:0] cnt_q, cnt_d;

    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_shift
            assign shift_in_val[gi]  = data_q[gi+1];
            assign shift_out_val[gi] = data_q[gi+1];
        end
    endgenerate
    assign shift_in_val[W-1]  = sdi_i;
    assign shift_out_val[W-1] = 1'b0;

    // Exposing the post-shift value lets the caller act on the final bit in the same edge.
    assign data_nxt_o = shift_in_val;
    assign lsb_o      = data_q[0];
    assign last_o     = (cnt_q == CW'(W - 1));

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        unique case (mode_i)
            SH_LOAD: begin
                data_d = din_i;
                cnt_d  = '0;
            end
            SH_SHIFT_IN: begin
                data_d = shift_in_val;
                cnt_d  = cnt_q + 1'b1;
            end
            SH_SHIFT_OUT: begin
                data_d = shift_out_val;
                cnt_d  = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_mem_bridge.sv
// Serial-frame responder that turns each frame into one req/ack bus transaction,
// with address range checking, a bus timeout and serialised read data on sdo.
module spi_mem_bridge
    import spi_pkg::*;
#(
    parameter int ADDR_LIMIT = DEF_ADDR_LIMIT,
    parameter int ADDR_W     = 8,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic sdi,
    output logic sdo,
    output logic ready,
    output logic op_done,
    output logic err,
    spi_mem_bridge_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    bridge_state_e     state_q, state_d;
    logic              wr_q, wr_d;
    logic [7:0]        addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        rdata_q, rdata_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [7:0]        bus_wdata_q, bus_wdata_d;

    sh_mode_e          sh_mode;
    logic [7:0]        sh_din;
    logic [7:0]        sh_nxt;
    logic              sh_lsb;
    logic              sh_last;

    logic [7:0]        addr_src;
    logic [ADDR_W-1:0] addr_fit;

    spi_bit_shifter #(.W(BYTE_BITS)) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .mode_i     (sh_mode),
        .din_i      (sh_din),
        .sdi_i      (sdi),
        .data_nxt_o (sh_nxt),
        .lsb_o      (sh_lsb),
        .last_o     (sh_last)
    );

    // Reads issue straight off the last address bit; writes use the captured address.
    assign addr_src = wr_q ? addr_q : sh_nxt;
    generate
        if (ADDR_W <= 8) begin : g_addr_trunc
            assign addr_fit = addr_src[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign addr_fit = {{(ADDR_W-8){1'b0}}, addr_src};
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        to_d        = to_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        sh_mode     = SH_HOLD;
        sh_din      = '0;

        unique case (state_q)
            ST_IDLE: begin
                sh_mode = SH_LOAD;
                err_d   = 1'b0;
                to_d    = '0;
                if (!cs) state_d = ST_CMD;
            end
            ST_CMD: begin
                sh_mode = SH_LOAD;
                if (cs) begin
                    state_d = ST_IDLE;
                end else begin
                    wr_d    = sdi;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cs) begin
                    state_d = ST_IDLE;
                end else if (sh_last) begin
                    sh_mode = SH_LOAD;
                    addr_d  = sh_nxt;
                    if (wr_q) begin
                        state_d = ST_DATA;
                    end else if (addr_in_range(sh_nxt, ADDR_LIMIT)) begin
                        bus_we_d   = 1'b0;
                        bus_addr_d = addr_fit;
                        state_d    = ST_BUS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = 8'h00;
                        state_d = ST_RESP;
                    end
                end else begin
                    sh_mode = SH_SHIFT_IN;
                end
            end
            ST_DATA: begin
                if (cs) begin
                    state_d = ST_IDLE;
                end else begin
                    sh_mode = SH_SHIFT_IN;
                    if (sh_last) begin
                        if (addr_in_range(addr_q, ADDR_LIMIT)) begin
                            bus_we_d    = 1'b1;
                            bus_addr_d  = addr_fit;
                            bus_wdata_d = sh_nxt;
                            state_d     = ST_BUS;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_BUS: begin
                // An ack in the final allowed cycle still wins over the timeout.
                if (bus.bus_ack) begin
                    if (!wr_q) rdata_d = bus.bus_rdata;
                    state_d = wr_q ? ST_DONE : ST_RESP;
                end else if (to_q == TO_LAST) begin
                    err_d = 1'b1;
                    if (!wr_q) rdata_d = 8'hFF;
                    state_d = wr_q ? ST_DONE : ST_RESP;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_RESP: begin
                sh_mode = SH_LOAD;
                sh_din  = rdata_q;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                sh_mode = SH_SHIFT_OUT;
                if (sh_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            to_q        <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            to_q        <= to_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign bus.bus_req   = (state_q == ST_BUS);
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

    assign ready   = (state_q == ST_RESP);
    assign op_done = (state_q == ST_DONE);
    assign err     = (state_q == ST_DONE) && err_q;
    assign sdo     = (state_q == ST_SEND) && sh_lsb;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: a vector table of frames with hand-computed
// timing and data, plus abort and mid-transaction reset sequences.
module tb_spi_mem_bridge;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cs  = 1'b1;
    logic sdi = 1'b0;
    logic sdo, ready, op_done, err;

    spi_mem_bridge_if #(.ADDR_W(8)) bus_if ();

    spi_mem_bridge #(
        .ADDR_LIMIT (32),
        .ADDR_W     (8),
        .TIMEOUT    (15)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .sdi     (sdi),
        .sdo     (sdo),
        .ready   (ready),
        .op_done (op_done),
        .err     (err),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         ack_delay;     // req cycles before ack; negative = never
        int         exp_req;       // total cycles bus_req is high
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_ready_off; // ready cycle relative to the last frame-bit cycle
        int         exp_done_off;
        logic       exp_wr_hit;
    } vec_t;

    vec_t vecs[10];

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         ack_delay = -1;
    logic [7:0] rdata_cfg = 8'h00;
    int         run_cnt, req_total, first_req, unstable;
    logic       req_we;
    logic [7:0] req_addr, req_wdata;
    int         wr_cnt;
    logic [7:0] wr_addr, wr_data;
    int         ready_cnt, ready_cyc, done_cnt, done_cyc;
    logic       done_err;
    logic [7:0] sdo_byte;
    int         sdo_stray, err_stray;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        run_cnt = 0; req_total = 0; first_req = -1; unstable = 0;
        req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        wr_cnt = 0; wr_addr = 8'h00; wr_data = 8'h00;
        ready_cnt = 0; ready_cyc = -100; done_cnt = 0; done_cyc = -100;
        done_err = 1'b0; sdo_byte = 8'h00; sdo_stray = 0; err_stray = 0;
    endtask

    // One clock step; sample outputs 1 time unit after the edge and update the bus model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.bus_req) begin
            run_cnt++;
            req_total++;
            if (run_cnt == 1) begin
                first_req = cyc;
                req_we    = bus_if.bus_we;
                req_addr  = bus_if.bus_addr;
                req_wdata = bus_if.bus_wdata;
            end else if (bus_if.bus_we !== req_we || bus_if.bus_addr !== req_addr ||
                         bus_if.bus_wdata !== req_wdata) begin
                unstable++;
            end
        end else begin
            run_cnt = 0;
        end
        bus_if.bus_ack   = bus_if.bus_req && (ack_delay >= 0) && (run_cnt > ack_delay);
        bus_if.bus_rdata = bus_if.bus_ack ? rdata_cfg : ~rdata_cfg;
        if (bus_if.bus_ack && bus_if.bus_we) begin
            wr_cnt++;
            wr_addr = bus_if.bus_addr;
            wr_data = bus_if.bus_wdata;
        end
        if (ready) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
        if (cyc > ready_cyc && cyc <= ready_cyc + 8) sdo_byte[cyc - ready_cyc - 1] = sdo;
        else if (sdo) sdo_stray++;
        if (op_done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end else if (err) begin
            err_stray++;
        end
    endtask

    task automatic send_bits(input logic [16:0] f, input int nb);
        cs  = 1'b0;
        sdi = 1'b0;
        tick();
        for (int i = 0; i < nb; i++) begin
            sdi = f[i];
            tick();
        end
        sdi = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [16:0] f;
        int nb, fe, budget;
        string p;
        clr();
        p = $sformatf("v%0d", idx);
        ack_delay = v.ack_delay;
        rdata_cfg = v.rdata;
        f  = {v.wdata, v.addr, v.wr};
        nb = v.wr ? WR_FRAME_BITS : RD_FRAME_BITS;
        send_bits(f, nb);
        fe = cyc;
        cs = 1'b1;
        budget = 0;
        while (done_cnt == 0 && budget < 60) begin
            tick();
            budget++;
        end
        tick();
        $display("%s: wr=%0d addr=%02h wdata=%02h req_cycles=%0d done_off=%0d err=%0d rd=%02h",
                 p, v.wr, v.addr, v.wdata, req_total, done_cyc - fe, done_err, sdo_byte);
        check({p, "_done_count"}, done_cnt, 1);
        check({p, "_done_off"}, done_cyc - fe, v.exp_done_off);
        check({p, "_done_err"}, done_err, v.exp_err);
        check({p, "_req_cycles"}, req_total, v.exp_req);
        if (v.exp_req > 0) begin
            check({p, "_req_start"}, first_req - fe, 0);
            check({p, "_req_we"}, req_we, v.wr);
            check({p, "_req_addr"}, req_addr, v.addr);
            check({p, "_req_stable"}, unstable, 0);
        end
        check({p, "_ready_count"}, ready_cnt, v.wr ? 0 : 1);
        if (!v.wr) begin
            check({p, "_ready_off"}, ready_cyc - fe, v.exp_ready_off);
            check({p, "_sdo_byte"}, sdo_byte, v.exp_rd);
        end
        check({p, "_wr_count"}, wr_cnt, v.exp_wr_hit ? 1 : 0);
        if (v.exp_wr_hit) begin
            check({p, "_wr_addr"}, wr_addr, v.addr);
            check({p, "_wr_data"}, wr_data, v.wdata);
        end
        check({p, "_sdo_idle"}, sdo_stray, 0);
        check({p, "_err_alone"}, err_stray, 0);
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_bus_req"}, bus_if.bus_req, 0);
        check({p, "_bus_we"}, bus_if.bus_we, 0);
        check({p, "_bus_addr"}, bus_if.bus_addr, 0);
        check({p, "_bus_wdata"}, bus_if.bus_wdata, 0);
        check({p, "_sdo"}, sdo, 0);
        check({p, "_ready"}, ready, 0);
        check({p, "_op_done"}, op_done, 0);
        check({p, "_err"}, err, 0);
    endtask

    initial begin
        vec_t v;
        //          wr    addr   wdata  rdata  dly req err   rd     rdy done hit
        vecs[0] = '{1'b1, 8'd5,  8'hA7, 8'h00,  2,  3, 1'b0, 8'h00, -1,  3, 1'b1};
        vecs[1] = '{1'b0, 8'd5,  8'h00, 8'h3C,  0,  1, 1'b0, 8'h3C,  1, 10, 1'b0};
        vecs[2] = '{1'b0, 8'd40, 8'h00, 8'h77,  0,  0, 1'b1, 8'h00,  0,  9, 1'b0};
        vecs[3] = '{1'b1, 8'd7,  8'h5A, 8'h00, -1, 15, 1'b1, 8'h00, -1, 15, 1'b0};
        vecs[4] = '{1'b0, 8'd9,  8'h00, 8'h12, -1, 15, 1'b1, 8'hFF, 15, 24, 1'b0};
        vecs[5] = '{1'b1, 8'd31, 8'h81, 8'h00,  0,  1, 1'b0, 8'h00, -1,  1, 1'b1};
        vecs[6] = '{1'b1, 8'd32, 8'h11, 8'h00,  0,  0, 1'b1, 8'h00, -1,  0, 1'b0};
        vecs[7] = '{1'b0, 8'd31, 8'h00, 8'hC3,  5,  6, 1'b0, 8'hC3,  6, 15, 1'b0};
        vecs[8] = '{1'b1, 8'd0,  8'hFF, 8'h00, 14, 15, 1'b0, 8'h00, -1, 15, 1'b1};
        vecs[9] = '{1'b0, 8'd6,  8'h00, 8'h01,  3,  4, 1'b0, 8'h01,  4, 13, 1'b0};

        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'h00;
        clr();
        rst = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Frame abandoned after bit 6, then a clean write.
        clr();
        send_bits({8'h55, 8'd3, 1'b1}, 7);
        cs = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        $display("abort: req_cycles=%0d ready=%0d done=%0d", req_total, ready_cnt, done_cnt);
        check("abort_req", req_total, 0);
        check("abort_ready", ready_cnt, 0);
        check("abort_done", done_cnt, 0);
        v = '{1'b1, 8'd3, 8'h55, 8'h00, 1, 2, 1'b0, 8'h00, -1, 2, 1'b1};
        run_vec(10, v);

        // Reset while a write waits for an ack that never comes.
        clr();
        ack_delay = -1;
        send_bits({8'h99, 8'd6, 1'b1}, WR_FRAME_BITS);
        cs = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rstbus_req_before", bus_if.bus_req, 1);
        rst = 1'b0;
        tick();
        $display("reset during bus: bus_req=%0d op_done=%0d", bus_if.bus_req, op_done);
        check_all_zero("rstbus");
        rst = 1'b1;
        tick();
        v = '{1'b0, 8'd5, 8'h00, 8'h3C, 0, 1, 1'b0, 8'h3C, 1, 10, 1'b0};
        run_vec(11, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

Memory-side responder for the single-clock serial link driven by `spi_master`. It deserialises write and read frames from `sdi`, turns each into one transaction on a local req/ack memory bus, and serialises read data back with the `ready`/`op_done` handshake the master expects. It replaces the internal array of `spi_memory` with an external bus port. It adds address range checking and a bus timeout.

## Interface
- `ADDR_LIMIT`, 32: addresses `>= ADDR_LIMIT` are out of range.
- `ADDR_W`, 8: width of `bus_addr`.
- `TIMEOUT`, 15: maximum number of cycles to wait for `bus_ack`.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-low.
- `cs`  in  1  frame select from master, active low.
- `sdi`  in  1  serial data from master (master `mosi`).
- `sdo`  out  1  serial read data to master (master `miso`).
- `ready`  out  1  one-cycle pulse: read data follows on `sdo`.
- `op_done`  out  1  one-cycle pulse: transaction complete.
- `err`  out  1  one-cycle pulse, coincident with `op_done`, on range error or timeout.
- `bus_req`  out  1  bus request.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  ADDR_W  bus address.
- `bus_wdata`  out  8  write data.
- `bus_ack`  in  1  bus acknowledge.
- `bus_rdata`  in  8  read data, valid in the `bus_ack` cycle.

## Operation
- Frame format is LSB first: bit0 = wr, bits 1..8 = addr, bits 9..16 = data (write only).
  - Write frame: 17 bits.
  - Read frame: 9 bits.
- States and transitions:
  - IDLE → CMD when `cs` is sampled low.
  - CMD samples wr, then → ADDR.
  - ADDR shifts 8 bits.
    - If wr: → DATA.
    - If read and in range: → BUS.
    - If read and out of range: → RESP.
  - DATA shifts 8 bits.
    - In range: → BUS.
    - Out of range: → DONE with `err`.
  - BUS holds `bus_req` until ack or timeout.
    - Write → DONE.
    - Read → RESP.
  - RESP pulses `ready`, then → SEND.
  - SEND drives 8 bits on `sdo`, then → DONE.
  - DONE pulses `op_done`, then → IDLE.
- `cs` rising during CMD, ADDR or DATA aborts the frame:
  - partial data is discarded;
  - no bus access, no `op_done`;
  - next state is IDLE.
- `cs` is ignored in BUS, RESP, SEND and DONE, because the master raises `cs` before the response.
- Bus handshake:
  - `bus_we`, `bus_addr` and `bus_wdata` are stable while `bus_req` is high.
  - `bus_req` drops the cycle after `bus_ack` is sampled high.
  - `bus_ack` is ignored while `bus_req` is low.
- Timeout: if ack is not seen within `TIMEOUT` cycles of `bus_req` rising:
  - `bus_req` drops and `err` is set for this transaction;
  - a read returns 8'hFF;
  - a write still produces `op_done`.
- Out-of-range read: no bus access; the returned data is 8'h00 and `err` pulses with `op_done`.
- Address compare uses the full 8-bit received address; `bus_addr` is the low `ADDR_W` bits.

## Timing
- Reset values: `sdo`, `ready`, `op_done`, `err` and `bus_req` are 0; `bus_we`, `bus_addr` and `bus_wdata` are 0; state is IDLE.
- Reset mid-operation takes effect on the next edge and abandons any bus request.
- Sampling: let edge E be the first edge where `cs` is sampled low. Frame bit i is sampled at edge E+1+i.
- Write: `bus_req` rises the cycle after frame bit 16 is sampled. With ack sampled at cycle A, `op_done` pulses at A+1.
- Read: `bus_req` rises the cycle after frame bit 8 is sampled.
  - With ack at cycle A, `ready` pulses at R = A+1.
  - Data bit j is driven on `sdo` during cycle R+1+j, for j = 0..7.
  - `op_done` pulses at R+9.
- Out-of-range read: R is the cycle after frame bit 8.
- `sdo` is 0 outside SEND.
- Minimum spacing: 1 idle cycle between `op_done` and the next accepted frame.

## Structure
- Package `spi_pkg` holds:
  - the bridge state enum;
  - `WR_FRAME_BITS` = 17 and `RD_FRAME_BITS` = 9;
  - the default values of `ADDR_LIMIT` and `TIMEOUT`.
- One sub-module, `spi_bit_shifter`: LSB-first shift register with a bit counter. It offers load/shift-in/shift-out modes and is used for both the receive path and the `sdo` serialiser.
- Top-level FSM, bus handshake and timeout counter live in `spi_mem_bridge`.

## Test plan
- Write frame: addr 5, data 8'hA7, ack after 2 cycles → one bus write of 8'hA7 to address 5, `bus_wdata` stable, then `op_done` pulse with `err`=0.
- Read frame: addr 5, `bus_rdata`=8'h3C, ack immediate → `ready` pulse, `sdo` carries 0,0,1,1,1,1,0,0 on R+1..R+8, then `op_done` pulse.
- Read of addr 40 → no `bus_req`; `sdo` carries 8'h00; `err` and `op_done` pulse together.
- Write with `bus_ack` held low → `bus_req` drops after 15 cycles; `err` and `op_done` pulse together. A read under the same condition returns 8'hFF.
- `cs` raised after frame bit 6 → no `bus_req` and no `op_done`; a following full write frame completes normally.
- `rst` low during BUS with `bus_req` high → all outputs 0 on the next edge; the next frame is accepted.
